// File: rtl/bram_req_adapter_if.sv
// Client-side request/response bundle for bram_req_adapter.
// master = client (LSU/DMA), slave = adapter.
interface bram_req_adapter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_DATA;
  logic                  RSP_WACK;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR,
    output REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID,
    input  RSP_DATA, RSP_WACK
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR,
    input  REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID,
    output RSP_DATA, RSP_WACK
  );
endinterface

// File: rtl/bram_req_adapter.sv
// Valid/ready front end for one port of a one-cycle block RAM.
// Optional write acks: define BRAM_REQ_ADAPTER_WRITE_ACK_EN.
module bram_req_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  bram_req_adapter_if.slave     cli,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  output logic                  BRAM_WE,
  output logic                  BRAM_RE,
  output logic                  BRAM_EN,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  input  logic                  BRAM_DO_VALID
);

`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  localparam int PW = (RSP_DEPTH > 1) ?
                      $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1) + 1;
  localparam logic [PW-1:0] LAST  = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] FULL  = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] LIMIT = CW'(RSP_DEPTH - 1);

  logic [FW-1:0] mem_q [RSP_DEPTH];
  logic [FW-1:0] mem_d [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          inflight_q, inflight_d;

  logic          fire;
  logic          track;
  logic          push;
  logic          pop;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head;

  // Ready only from registered state; one slot kept for this cycle's issue.
  assign cli.REQ_READY = !RST &&
    ((occ_q + CW'(inflight_q)) < LIMIT);

  assign fire      = cli.REQ_VALID & cli.REQ_READY;
  assign BRAM_EN   = fire;
  assign BRAM_WE   = fire & cli.REQ_WE;
  assign BRAM_RE   = fire & ~cli.REQ_WE;
  assign BRAM_ADDR = cli.REQ_ADDR;
  assign BRAM_DI   = cli.REQ_WDATA;

  // Stray DO_VALID without an outstanding request is dropped.
  assign push = BRAM_DO_VALID & inflight_q;
  assign pop  = (occ_q != '0) & cli.RSP_READY;
  assign head = mem_q[rd_ptr_q];

  assign cli.RSP_VALID = (occ_q != '0);
  assign cli.RSP_DATA  = head[DATA_WIDTH-1:0];

`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
  logic wack_q, wack_d;

  assign track        = fire;
  assign wack_d       = fire & cli.REQ_WE;
  assign push_data    = {wack_q, BRAM_DO};
  assign cli.RSP_WACK = head[FW-1];

  // Remember whether the outstanding op is a write.
  always_ff @(posedge CLK) begin
    if (RST) wack_q <= 1'b0;
    else     wack_q <= wack_d;
  end
`else
  assign track        = fire & ~cli.REQ_WE;
  assign push_data    = BRAM_DO;
  assign cli.RSP_WACK = 1'b0;
`endif

  // Next-state for FIFO storage, pointers, occupancy, inflight.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = track;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST) ?
                 '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ?
                 '0 : rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RSP_DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (RST)
    !(push && !pop && occ_q == FULL));

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed bench for bram_req_adapter with a one-cycle
// write-first RAM model.
module tb_bram_req_adapter;
  logic        clk;
  logic        rst;
  logic [8:0]  bram_addr;
  logic [31:0] bram_di;
  logic        bram_we, bram_re, bram_en;
  logic [31:0] ram_do;
  logic        ram_vld;
  logic        stray;
  logic        do_valid;

  int checks;
  int failures;
  int cyc;
  int acc;
  int iss;
  logic [31:0] ram [0:511];
  logic [32:0] rq [$];
  int          rc [$];

  bram_req_adapter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) cli();

  bram_req_adapter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .RSP_DEPTH(4)
  ) dut (
    .CLK(clk), .RST(rst), .cli(cli),
    .BRAM_ADDR(bram_addr), .BRAM_DI(bram_di),
    .BRAM_WE(bram_we), .BRAM_RE(bram_re),
    .BRAM_EN(bram_en), .BRAM_DO(ram_do),
    .BRAM_DO_VALID(do_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign do_valid = ram_vld | stray;

  // One-cycle RAM, write-first.
  always @(posedge clk) begin
    ram_vld <= bram_en;
    if (bram_en && bram_we) begin
      ram[bram_addr] <= bram_di;
      ram_do <= bram_di;
    end else if (bram_en && bram_re) begin
      ram_do <= ram[bram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshaked response with its cycle.
  always @(negedge clk) begin
    if (!rst && cli.RSP_VALID && cli.RSP_READY) begin
      rq.push_back({cli.RSP_WACK, cli.RSP_DATA});
      rc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sexp(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'h1234_5678;
    return 32'hA500_0000 | i;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    stray = 1'b0;
    ram_vld = 1'b0;
    ram_do = '0;
    for (int i = 0; i < 512; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++)
      ram[i] = 32'hA500_0000 | i;
    ram[5] = 32'hDEADBEEF;
    for (int i = 20; i < 24; i++)
      ram[i] = 32'hB000_0000 | i;
    ram[30] = 32'hC0FF_EE30;

    rst = 1'b1;
    cli.REQ_VALID = 1'b1;
    cli.REQ_WE    = 1'b0;
    cli.REQ_ADDR  = '0;
    cli.REQ_WDATA = '0;
    cli.RSP_READY = 1'b1;

    // reset: request valid must be ignored
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(cli.REQ_READY), 0);
      chk("rst_bram_en", 32'(bram_en), 0);
      chk("rst_rsp_valid", 32'(cli.RSP_VALID), 0);
      nxt();
    end
    rst = 1'b0;
    cli.REQ_VALID = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(cli.REQ_READY), 1);
    chk("idle_rsp_valid", 32'(cli.RSP_VALID), 0);
    chk("idle_bram_en", 32'(bram_en), 0);
    chk("idle_rsp_data", cli.RSP_DATA, 0);
    chk("idle_rsp_wack", 32'(cli.RSP_WACK), 0);
    nxt();

    // single read of addr 5
    rq.delete(); rc.delete();
    cli.REQ_VALID = 1'b1;
    cli.REQ_ADDR  = 9'd5;
    @(negedge clk);
    chk("rd_bram_en", 32'(bram_en), 1);
    chk("rd_bram_re", 32'(bram_re), 1);
    chk("rd_bram_we", 32'(bram_we), 0);
    chk("rd_bram_addr", 32'(bram_addr), 5);
    nxt();
    cli.REQ_VALID = 1'b0;
    @(negedge clk);
    chk("rd_t1_rsp_valid", 32'(cli.RSP_VALID), 0);
    nxt();
    @(negedge clk);
    chk("rd_t2_rsp_valid", 32'(cli.RSP_VALID), 1);
    chk("rd_t2_rsp_data", cli.RSP_DATA, 32'hDEADBEEF);
    chk("rd_t2_rsp_wack", 32'(cli.RSP_WACK), 0);
    nxt();
    @(negedge clk);
    chk("rd_t3_rsp_valid", 32'(cli.RSP_VALID), 0);
    chk("rd_count", 32'(rq.size()), 1);

    // stray DO_VALID with nothing outstanding
    nxt();
    stray = 1'b1;
    nxt();
    stray = 1'b0;
    nxt();
    @(negedge clk);
    chk("stray_rsp_valid", 32'(cli.RSP_VALID), 0);

    // write 7 then read 7
    nxt();
    rq.delete(); rc.delete();
    cli.REQ_VALID = 1'b1;
    cli.REQ_WE    = 1'b1;
    cli.REQ_ADDR  = 9'd7;
    cli.REQ_WDATA = 32'h1234_5678;
    @(negedge clk);
    chk("wr_bram_we", 32'(bram_we), 1);
    chk("wr_bram_di", bram_di, 32'h1234_5678);
    nxt();
    cli.REQ_WE = 1'b0;
    nxt();
    cli.REQ_VALID = 1'b0;
    repeat (6) nxt();
`ifdef BRAM_REQ_ADAPTER_WRITE_ACK_EN
    chk("wr_rd_count", 32'(rq.size()), 2);
    if (rq.size() == 2) begin
      chk("wack0_flag", 32'(rq[0][32]), 1);
      chk("wack0_data", rq[0][31:0], 32'h1234_5678);
      chk("rd1_flag", 32'(rq[1][32]), 0);
      chk("rd1_data", rq[1][31:0], 32'h1234_5678);
    end
`else
    chk("wr_rd_count", 32'(rq.size()), 1);
    if (rq.size() == 1) begin
      chk("wr_rd_flag", 32'(rq[0][32]), 0);
      chk("wr_rd_data", rq[0][31:0], 32'h1234_5678);
    end
`endif

    // 16 back-to-back reads
    rq.delete(); rc.delete();
    iss = 0;
    for (int i = 0; i < 16; i++) begin
      cli.REQ_VALID = 1'b1;
      cli.REQ_ADDR  = 9'(i);
      @(negedge clk);
      if (i == 0) iss = cyc;
      chk($sformatf("strm_ready_%0d", i),
          32'(cli.REQ_READY), 1);
      nxt();
    end
    cli.REQ_VALID = 1'b0;
    repeat (6) nxt();
    chk("strm_count", 32'(rq.size()), 16);
    if (rq.size() == 16) begin
      chk("strm_latency", 32'(rc[0]), 32'(iss + 2));
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("strm_data_%0d", i),
            rq[i][31:0], sexp(i));
        chk($sformatf("strm_cyc_%0d", i),
            32'(rc[i]), 32'(rc[0] + i));
      end
    end

    // backpressure
    rq.delete(); rc.delete();
    cli.RSP_READY = 1'b0;
    cli.REQ_VALID = 1'b1;
    cli.REQ_ADDR  = 9'd20;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cli.REQ_READY) acc++;
      nxt();
      cli.REQ_ADDR = 9'(20 + acc);
    end
    chk("bp_accepted", 32'(acc), 3);
    @(negedge clk);
    chk("bp_req_ready", 32'(cli.REQ_READY), 0);
    cli.REQ_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(cli.RSP_VALID), 1);
      chk("bp_hold_data", cli.RSP_DATA, 32'hB000_0014);
      nxt();
    end
    cli.RSP_READY = 1'b1;
    repeat (6) nxt();
    chk("bp_count", 32'(rq.size()), 3);
    if (rq.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_data_%0d", i), rq[i][31:0],
            32'hB000_0000 | (20 + i));
    end

    // reset one cycle after a read fires
    rq.delete(); rc.delete();
    cli.REQ_VALID = 1'b1;
    cli.REQ_ADDR  = 9'd30;
    nxt();
    cli.REQ_VALID = 1'b0;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    repeat (5) nxt();
    chk("mid_rst_count", 32'(rq.size()), 0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(cli.RSP_VALID), 0);
    chk("mid_rst_ready", 32'(cli.REQ_READY), 1);
    nxt();
    cli.REQ_VALID = 1'b1;
    nxt();
    cli.REQ_VALID = 1'b0;
    repeat (5) nxt();
    chk("post_rst_count", 32'(rq.size()), 1);
    if (rq.size() == 1)
      chk("post_rst_data", rq[0][31:0], 32'hC0FF_EE30);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
